// File: rtl/serial_addsub_if.sv
// Start/busy/done handshake and operand/result bundle for serial_addsub.
// The master drives the request side; the slave returns status and result.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, mode, a, b, cin,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, mode, a, b, cin,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one shared BITS_PER_CYCLE-wide chunk adder walks
// the operands LSB chunk first; results and flags are registered and held.
module serial_addsub #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                state_r;
    logic [1:0]                state_next_s;
    logic [CW-1:0]             count_r;
    logic [WIDTH-1:0]          a_r;
    logic [WIDTH-1:0]          b_r;
    logic                      c_r;
    logic                      mode_r;
    logic [WIDTH-1:0]          res_r;
    logic [WIDTH-1:0]          sum_r;
    logic                      cout_r;
    logic                      ovf_r;
    logic                      zero_r;
    logic                      busy_r;
    logic                      done_r;

    logic [BITS_PER_CYCLE:0]   chunk_s;
    logic [BITS_PER_CYCLE-1:0] chunk_sum_s;
    logic                      chunk_carry_s;
    logic                      msb_cin_s;
    logic [WIDTH+BITS_PER_CYCLE-1:0] shifted_s;
    logic [WIDTH-1:0]          res_next_s;
    logic                      last_s;
    logic                      accept_s;

    // Shared chunk adder and result-register shift path.
    always_comb begin
        chunk_s       = {1'b0, a_r[BITS_PER_CYCLE-1:0]}
                      + {1'b0, b_r[BITS_PER_CYCLE-1:0]}
                      + {{BITS_PER_CYCLE{1'b0}}, c_r};
        chunk_sum_s   = chunk_s[BITS_PER_CYCLE-1:0];
        chunk_carry_s = chunk_s[BITS_PER_CYCLE];
        // On the last chunk its top bit is the word MSB, so this is the carry into the MSB.
        msb_cin_s     = chunk_sum_s[BITS_PER_CYCLE-1] ^ a_r[BITS_PER_CYCLE-1]
                      ^ b_r[BITS_PER_CYCLE-1];
        shifted_s     = {chunk_sum_s, res_r};
        res_next_s    = shifted_s[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
        last_s        = (count_r == CW'(N - 1));
        accept_s      = bus.start && ((state_r == IDLE) || (state_r == DONE));
    end

    // Next-state logic of the IDLE/RUN/DONE controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_next_s = RUN;
                else           state_next_s = IDLE;
            end
            RUN: begin
                if (last_s) state_next_s = DONE;
                else        state_next_s = RUN;
            end
            DONE: begin
                if (bus.start) state_next_s = RUN;
                else           state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath, status and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            count_r <= {CW{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            mode_r  <= 1'b0;
            res_r   <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
            done_r  <= (state_next_s == DONE);
            if (accept_s) begin
                // Subtraction is a + ~b + ~borrow through the same adder.
                a_r     <= bus.a;
                b_r     <= bus.mode ? ~bus.b : bus.b;
                c_r     <= bus.mode ? ~bus.cin : bus.cin;
                mode_r  <= bus.mode;
                count_r <= {CW{1'b0}};
            end else if (state_r == RUN) begin
                a_r     <= a_r >> BITS_PER_CYCLE;
                b_r     <= b_r >> BITS_PER_CYCLE;
                c_r     <= chunk_carry_s;
                res_r   <= res_next_s;
                count_r <= count_r + CW'(1);
                if (last_s) begin
                    sum_r  <= res_next_s;
                    cout_r <= mode_r ? ~chunk_carry_s : chunk_carry_s;
                    ovf_r  <= msb_cin_s ^ chunk_carry_s;
                    zero_r <= (res_next_s == {WIDTH{1'b0}});
                end
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
    assign bus.zero = zero_r;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (8/1, 8/4, 1/1) driven by directed and
// random operations, checked against an arithmetic reference model.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [10:0] prev [3];

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8)) i8 ();
    serial_addsub_if #(.WIDTH(8)) i84 ();
    serial_addsub_if #(.WIDTH(1)) i1 ();

    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut84 (.clk(clk), .rst_n(rst_n), .bus(i84));
    serial_addsub #(.WIDTH(1), .BITS_PER_CYCLE(1)) dut1  (.clk(clk), .rst_n(rst_n), .bus(i1));

    function automatic int width_of(input int sel);
        return (sel == 2) ? 1 : 8;
    endfunction

    function automatic int chunks_of(input int sel);
        return (sel == 0) ? 8 : ((sel == 1) ? 2 : 1);
    endfunction

    // Reference: {zero, ovf, cout, sum[7:0]} from plain integer arithmetic.
    function automatic logic [10:0] model(input int w, input logic md, input logic [7:0] av,
                                          input logic [7:0] bv, input logic ci);
        int m, ua, ub, c, sa, sb, r, sr, s, co, ov;
        logic [7:0] s8;
        m  = 1 << w;
        ua = int'(av);
        ub = int'(bv);
        c  = ci ? 1 : 0;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (!md) begin
            r  = ua + ub + c;
            sr = sa + sb + c;
            co = (r >= m) ? 1 : 0;
        end else begin
            r  = ua - ub - c;
            sr = sa - sb - c;
            co = (ua < ub + c) ? 1 : 0;
        end
        s  = ((r % m) + m) % m;
        ov = (sr < -(m / 2) || sr > (m / 2 - 1)) ? 1 : 0;
        s8 = s[7:0];
        return {(s == 0), (ov == 1), (co == 1), s8};
    endfunction

    function automatic logic [12:0] obs(input int sel);
        case (sel)
            0:       return {i8.busy, i8.done, i8.zero, i8.ovf, i8.cout, i8.sum};
            1:       return {i84.busy, i84.done, i84.zero, i84.ovf, i84.cout, i84.sum};
            default: return {i1.busy, i1.done, i1.zero, i1.ovf, i1.cout, 7'd0, i1.sum};
        endcase
    endfunction

    task automatic drive(input int sel, input logic st, input logic md, input logic [7:0] av,
                         input logic [7:0] bv, input logic ci);
        case (sel)
            0: begin i8.start = st; i8.mode = md; i8.a = av; i8.b = bv; i8.cin = ci; end
            1: begin i84.start = st; i84.mode = md; i84.a = av; i84.b = bv; i84.cin = ci; end
            default: begin i1.start = st; i1.mode = md; i1.a = av[0:0]; i1.b = bv[0:0]; i1.cin = ci; end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic scramble(input int sel, input logic st);
        logic [7:0] ra, rb;
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        drive(sel, st, 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
    endtask

    task automatic idle_check(input int sel, input int cycles);
        logic [12:0] o;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            o = obs(sel);
            check("idle_busy_done", {30'd0, o[12:11]}, 32'd0);
            check("idle_hold", {21'd0, o[10:0]}, {21'd0, prev[sel]});
        end
    endtask

    // Starts an operation in the current cycle (called #1 after an edge) and
    // returns #1 after the edge at which done is seen.
    task automatic run_op(input int sel, input logic md, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input int intr, input int rst_at);
        logic [10:0] exp;
        logic [12:0] o;
        int lat, bc, n;
        bit got_done;
        n        = chunks_of(sel);
        exp      = model(width_of(sel), md, av, bv, ci);
        lat      = 0;
        bc       = 0;
        got_done = 1'b0;
        drive(sel, 1'b1, md, av, bv, ci);
        while (!got_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) scramble(sel, 1'b0);
            if (intr != 0 && lat == intr) scramble(sel, 1'b1);
            if (intr != 0 && lat == intr + 1) scramble(sel, 1'b0);
            o = obs(sel);
            if (o[11]) begin
                got_done = 1'b1;
            end else begin
                if (o[12]) bc++;
                check("run_hold", {21'd0, o[10:0]}, {21'd0, prev[sel]});
            end
            if (rst_at != 0 && lat == rst_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    o = obs(s);
                    check("midrun_reset", {19'd0, o}, 32'd0);
                    prev[s] = 11'd0;
                end
                idle_check(sel, 15);
                return;
            end
        end
        check("latency", lat, n + 1);
        check("busy_cycles", bc, n);
        check("done_busy_low", {31'd0, o[12]}, 32'd0);
        check("result", {21'd0, o[10:0]}, {21'd0, exp});
        prev[sel] = exp;
    endtask

    initial begin
        logic [12:0] o;
        logic [7:0]  ra, rb;
        logic [2:0]  v;
        for (int s = 0; s < 3; s++) begin
            drive(s, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
            prev[s] = 11'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            o = obs(s);
            check("reset_state", {19'd0, o}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors on the 8-bit, 1-bit-per-cycle instance.
        run_op(0, 1'b0, 8'h7F, 8'h01, 1'b0, 0, 0);
        o = obs(0);
        check("tp_7f_plus_1", {21'd0, o[10:0]}, {21'd0, 1'b0, 1'b1, 1'b0, 8'h80});
        idle_check(0, 2);
        run_op(0, 1'b1, 8'h05, 8'h05, 1'b0, 0, 0);
        idle_check(0, 1);
        run_op(0, 1'b1, 8'h03, 8'h05, 1'b0, 0, 0);
        idle_check(0, 1);
        run_op(0, 1'b1, 8'h80, 8'h01, 1'b0, 0, 0);
        idle_check(0, 1);
        run_op(0, 1'b0, 8'hFF, 8'h01, 1'b1, 3, 0);
        idle_check(0, 12);
        run_op(0, 1'b0, 8'hFF, 8'h01, 1'b1, 0, 0);
        run_op(0, 1'b1, 8'h10, 8'h20, 1'b1, 0, 0);
        idle_check(0, 1);
        run_op(0, 1'b0, 8'h3C, 8'h44, 1'b0, 0, 4);

        // Random operations, some issued back-to-back in the DONE cycle.
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(0, 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), 0, 0);
            if ($urandom_range(0, 1) == 0) idle_check(0, 1);
        end
        idle_check(0, 1);

        // Four bits per cycle.
        run_op(1, 1'b0, 8'hA5, 8'h5A, 1'b0, 0, 0);
        idle_check(1, 1);
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(1, 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), 0, 0);
            if ($urandom_range(0, 1) == 0) idle_check(1, 1);
        end
        idle_check(1, 1);

        // One-bit instance: full adder/subtractor truth table in both modes.
        for (int md = 0; md < 2; md++) begin
            for (int k = 0; k < 8; k++) begin
                v = 3'(k);
                run_op(2, 1'(md), {7'd0, v[2]}, {7'd0, v[1]}, v[0], 0, 0);
                idle_check(2, 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
